// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regFile write port, plus a per-register busy scoreboard.
// Define REGFILE_WB_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_W-1:0]  req_num,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rf_hold,
  output logic                      rf_write_en,
  output logic [REG_W-1:0]          rf_reg_num,
  output logic [DATA_W-1:0]         rf_reg_data_in,
  input  logic                      sb_set_en,
  input  logic [REG_W-1:0]          sb_set_num,
  output logic [(2**REG_W)-1:0]     sb_busy,
  input  logic [REG_W-1:0]          rd_num,
  output logic                      rd_stall
);
  localparam int NUM_REG = 2**REG_W;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic               accept;
  logic [REG_W-1:0]   win_num;
  logic [DATA_W-1:0]  win_data;
  logic [NUM_REG-1:0] sb_next;

`ifdef REGFILE_WB_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Search upward from rr_ptr with wrap-around; first valid requester wins.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[k]) begin
        found   = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end
`endif

  // Ready is forced low during reset and while regFile is held.
  always_comb begin
    accept    = found && !rf_hold && reset;
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
    win_num  = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == win_idx) begin
        win_num  = req_num[k*REG_W +: REG_W];
        win_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Set is applied after clear so a newer producer keeps the register busy.
  always_comb begin
    sb_next = sb_busy;
    if (accept)    sb_next[win_num]    = 1'b0;
    if (sb_set_en) sb_next[sb_set_num] = 1'b1;
  end

  assign rd_stall = reset && sb_busy[rd_num];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_en    <= 1'b0;
      rf_reg_num     <= '0;
      rf_reg_data_in <= '0;
      sb_busy        <= '0;
    end else begin
      rf_write_en <= accept;
      if (accept) begin
        rf_reg_num     <= win_num;
        rf_reg_data_in <= win_data;
      end
      sb_busy <= sb_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_num;
  logic [95:0] req_data;
  logic        rf_hold;
  logic        rf_write_en;
  logic [3:0]  rf_reg_num;
  logic [31:0] rf_reg_data_in;
  logic        sb_set_en;
  logic [3:0]  sb_set_num;
  logic [15:0] sb_busy;
  logic [3:0]  rd_num;
  logic        rd_stall;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_num(req_num), .req_data(req_data),
    .rf_hold(rf_hold), .rf_write_en(rf_write_en), .rf_reg_num(rf_reg_num),
    .rf_reg_data_in(rf_reg_data_in), .sb_set_en(sb_set_en), .sb_set_num(sb_set_num),
    .sb_busy(sb_busy), .rd_num(rd_num), .rd_stall(rd_stall)
  );

  always #5 clk = ~clk;

  // Expected winner from the arbitration rules: no grant under hold, otherwise the first
  // valid requester found scanning upward from ptr (ptr is always 0 for fixed priority).
  function automatic int model_winner(input logic [2:0] v, input logic hold, input int ptr);
    int w;
    w = -1;
    if (!hold) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (ptr + k) % 3;
        if (w < 0 && v[i]) w = i;
      end
    end
    return w;
  endfunction

  task automatic clear_inputs;
    req_valid = '0; req_num = '0; req_data = '0; rf_hold = 1'b0;
    sb_set_en = 1'b0; sb_set_num = '0; rd_num = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] num, input logic [31:0] data);
    req_valid[i]        = 1'b1;
    req_num[i*4 +: 4]   = num;
    req_data[i*32 +: 32] = data;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    req_valid = 3'b111;
    #1;
    checks++;
    if ({req_ready, rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy, rd_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b we=%b num=%h data=%h busy=%h stall=%b want all 0",
               req_ready, rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy, rd_stall);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_write;
    @(negedge clk);
    set_req(1, 4'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready got %b want 010", req_ready);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checks++;
    if ({rf_write_en, rf_reg_num, rf_reg_data_in} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_write got we=%b num=%0d data=%h want 1/5/deadbeef",
               rf_write_en, rf_reg_num, rf_reg_data_in);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_write_en, rf_reg_num, rf_reg_data_in} !== {1'b0, 4'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_idle got we=%b num=%0d data=%h want 0/5/deadbeef",
               rf_write_en, rf_reg_num, rf_reg_data_in);
    end
  endtask

  task automatic test_all_valid;
    logic [31:0] cur_data [3];
    logic [2:0]  exp_rdy;
    int          w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cur_data[i] = 32'h1000 + 32'(i);
      set_req(i, 4'(i + 1), cur_data[i]);
    end
    for (int c = 0; c < 6; c++) begin
      w = RR ? (c % 3) : 0;
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL all_valid_ready cycle %0d got %b want %b", c, req_ready, exp_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_write_en, rf_reg_num, rf_reg_data_in} !== {1'b1, 4'(w + 1), cur_data[w]}) begin
        errors++;
        $display("FAIL all_valid_write cycle %0d got we=%b num=%0d data=%h want 1/%0d/%h",
                 c, rf_write_en, rf_reg_num, rf_reg_data_in, w + 1, cur_data[w]);
      end
      cur_data[w] = 32'h2000 + 32'(c * 16 + w);
      set_req(w, 4'(w + 1), cur_data[w]);
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_num = 4'd7; rd_num = 4'd7;
    #1;
    checks++;
    if (rd_stall !== 1'b0) begin
      errors++; $display("FAIL sb_pre_set_stall got %b want 0", rd_stall);
    end
    @(posedge clk); #1;
    sb_set_en = 1'b0;
    checks++;
    if ({sb_busy[7], rd_stall} !== 2'b11) begin
      errors++; $display("FAIL sb_set got busy7=%b stall=%b want 1/1", sb_busy[7], rd_stall);
    end
    @(negedge clk);
    set_req(0, 4'd7, 32'h0000_0777);
    #1;
    checks++;
    if ({req_ready, rd_stall} !== {3'b001, 1'b1}) begin
      errors++; $display("FAIL sb_accept_cycle got ready=%b stall=%b want 001/1", req_ready, rd_stall);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if ({sb_busy[7], rd_stall, rf_write_en, rf_reg_num} !== {1'b0, 1'b0, 1'b1, 4'd7}) begin
      errors++;
      $display("FAIL sb_clear got busy7=%b stall=%b we=%b num=%0d want 0/0/1/7",
               sb_busy[7], rd_stall, rf_write_en, rf_reg_num);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_set_clear_same;
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_num = 4'd3; rd_num = 4'd3;
    set_req(2, 4'd3, 32'h0000_0333);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL same_reg_ready got %b want 100", req_ready);
    end
    @(posedge clk); #1;
    clear_inputs();
    rd_num = 4'd3;
    checks++;
    if ({sb_busy[3], rd_stall, rf_write_en, rf_reg_num} !== {1'b1, 1'b1, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL same_reg_set_wins got busy3=%b stall=%b we=%b num=%0d want 1/1/1/3",
               sb_busy[3], rd_stall, rf_write_en, rf_reg_num);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_hold;
    @(negedge clk);
    rf_hold = 1'b1;
    set_req(2, 4'd9, 32'h0000_0999);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL hold_ready cycle %0d got %b want 000", c, req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rf_write_en !== 1'b0) begin
        errors++; $display("FAIL hold_we cycle %0d got %b want 0", c, rf_write_en);
      end
      @(negedge clk);
    end
    rf_hold = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL hold_release_ready got %b want 100", req_ready);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    checks++;
    if ({rf_write_en, rf_reg_num, rf_reg_data_in} !== {1'b1, 4'd9, 32'h0000_0999}) begin
      errors++;
      $display("FAIL hold_release_write got we=%b num=%0d data=%h want 1/9/00000999",
               rf_write_en, rf_reg_num, rf_reg_data_in);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_req(1, 4'hA, 32'h0000_AAAA);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    set_req(0, 4'hB, 32'h0000_00B0);
    set_req(2, 4'hC, 32'h0000_00C0);
    #1;
    checks++;
    if (req_ready !== (RR ? 3'b100 : 3'b001)) begin
      errors++; $display("FAIL mid_pre_reset_ready got %b want %b", req_ready, RR ? 3'b100 : 3'b001);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs ready=%b we=%b num=%h data=%h busy=%h want all 0",
               req_ready, rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL mid_release_ready got %b want 001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if ({rf_write_en, rf_reg_num, rf_reg_data_in} !== {1'b1, 4'hB, 32'h0000_00B0}) begin
      errors++;
      $display("FAIL mid_release_write got we=%b num=%h data=%h want 1/b/000000b0",
               rf_write_en, rf_reg_num, rf_reg_data_in);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_random;
    int          m_ptr;
    logic [15:0] m_busy;
    logic        m_we;
    logic [3:0]  m_num;
    logic [31:0] m_data;
    logic [2:0]  exp_rdy;
    int          w;
    do_reset();
    m_ptr = 0; m_busy = '0; m_we = 1'b0; m_num = '0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!req_valid[i] && $urandom_range(0, 99) < 50)
          set_req(i, 4'($urandom_range(0, 15)), $urandom);
      rf_hold    = ($urandom_range(0, 4) == 0);
      sb_set_en  = ($urandom_range(0, 2) == 0);
      sb_set_num = 4'($urandom_range(0, 15));
      rd_num     = 4'($urandom_range(0, 15));
      #1;
      w = model_winner(req_valid, rf_hold, m_ptr);
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy || rd_stall !== m_busy[rd_num]) begin
        errors++;
        $display("FAIL rand_comb cycle %0d got ready=%b stall=%b want ready=%b stall=%b",
                 c, req_ready, rd_stall, exp_rdy, m_busy[rd_num]);
      end
      if (w >= 0) begin
        m_we = 1'b1;
        m_num = req_num[w*4 +: 4];
        m_data = req_data[w*32 +: 32];
        m_busy[m_num] = 1'b0;
        m_ptr = RR ? (w + 1) % 3 : 0;
      end else begin
        m_we = 1'b0;
      end
      if (sb_set_en) m_busy[sb_set_num] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy} !== {m_we, m_num, m_data, m_busy}) begin
        errors++;
        $display("FAIL rand_seq cycle %0d got we=%b num=%h data=%h busy=%h want we=%b num=%h data=%h busy=%h",
                 c, rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy, m_we, m_num, m_data, m_busy);
      end
      if (w >= 0) req_valid[w] = 1'b0;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_write();
    test_all_valid();
    test_scoreboard();
    test_set_clear_same();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of `regFile` between multiple writeback requesters (ALU, load/store unit, PC/link update) using a valid/ready handshake. It drives the register-file write port from registered outputs. It also keeps a per-register busy scoreboard so decode can detect read-after-write hazards. It sits between the execute/memory stages and `regFile`.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, register data width
- REG_W, 4, register number width; register count is 2**REG_W (16)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&&ready
- req_num  in  NUM_REQ*REG_W  flattened target register numbers; requester i uses slice [i*REG_W +: REG_W]
- req_data  in  NUM_REQ*DATA_W  flattened write data, sliced the same way
- rf_hold  in  1  when high, no grant is issued
- rf_write_en  out  1  registered write enable to `regFile`
- rf_reg_num  out  REG_W  registered target register
- rf_reg_data_in  out  DATA_W  registered write data
- sb_set_en  in  1  decode marks a register as having a pending producer
- sb_set_num  in  REG_W  register to mark busy
- sb_busy  out  2**REG_W  scoreboard, one bit per register
- rd_num  in  REG_W  register that decode wants to read
- rd_stall  out  1  combinational: sb_busy[rd_num]

## Operation
- Arbitration is evaluated combinationally every cycle. At most one req_ready bit is high, and only for a requester whose valid is high. All ready bits are 0 when rf_hold=1.
- Requesters hold valid, num and data stable until accepted. They do not withdraw a request once valid is high.
- Winner selection, round-robin: the search starts at rr_ptr and moves upward with wrap-around. The first valid requester found wins. After an accepted grant to requester i, rr_ptr becomes (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- On acceptance, on the next edge:
  - rf_write_en=1.
  - rf_reg_num and rf_reg_data_in capture the winner's num and data.
  - sb_busy[num] clears.
- With no acceptance, rf_write_en=0 and rf_reg_num/rf_reg_data_in hold their last values.
- Scoreboard updates:
  - On sb_set_en, sb_busy[sb_set_num] sets on the next edge.
  - If set and clear hit the same register in the same cycle, set wins (a newer producer is pending).
  - Setting an already-busy bit leaves it at 1; producers are not counted.
- Two requesters targeting the same register are serialized by the arbiter. The later-granted write is the final value.

## Timing
- Reset (reset=0, asynchronous), all of the following are 0: rf_write_en, rf_reg_num, rf_reg_data_in, sb_busy, rr_ptr.
  - req_ready and rd_stall evaluate to 0 while reset is asserted.
- Reset mid-operation: any in-flight write is dropped. Requesters still asserting valid are re-arbitrated from rr_ptr=0 after release.
- Latency is 1 cycle from acceptance to rf_write_en. Throughput is one write per cycle.
- req_ready depends combinationally on req_valid, rr_ptr and rf_hold. Requesters must not make valid depend on ready.
- rd_stall reflects sb_busy as registered, so a clear becomes visible the cycle after acceptance. This matches `regFile` holding the new data that cycle.
- rf_hold asserted in a cycle blocks that cycle's grant only; it does not affect rr_ptr or the scoreboard.

## Configuration
- REGFILE_WB_ARB_RR_EN
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, where the lowest valid index wins. rr_ptr is not implemented, and all other behaviour is identical.

## Test plan
- Reset, then requester 1 valid with num=5, data=0xDEADBEEF: req_ready=3'b010 in the same cycle. Next cycle rf_write_en=1, rf_reg_num=5, rf_reg_data_in=0xDEADBEEF; the cycle after, rf_write_en=0.
- All 3 requesters held valid for 6 cycles (RR_EN defined): grants go 0,1,2,0,1,2. With RR_EN undefined: grants go 0 every cycle while requester 0 stays valid.
- sb_set_en with num=7, then rd_num=7: rd_stall=1. Accept a write to r7: sb_busy[7]=0 and rd_stall=0 one cycle after acceptance.
- Same-cycle sb_set_num=3 and accepted write to r3: sb_busy[3] stays 1.
- rf_hold=1 for 2 cycles with requester 2 valid: no ready, no rf_write_en. On release: grant to requester 2 the same cycle.
- Assert reset while a grant is pending: all outputs go to 0 immediately. After release, requester 0 (still valid) is granted first.
